// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path, also intended for the
// future transmitter:
//   - rx_state_e     : receiver FSM state encoding
//   - par_mode_e     : parity-mode encoding (none / odd / even)
//   - DATA_BITS_OFFSET : cfg_data_bits value 0 corresponds to 5 data bits
//   - BIT_TIMER_W    : width of the bit-period down-counter
//   - parity_bit()   : expected parity bit for a data word
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS_OFFSET = 5;
    localparam int BIT_TIMER_W      = 17;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP1     = 3'd4,
        RX_STOP2     = 3'd5,
        RX_WAIT_IDLE = 3'd6
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } par_mode_e;

    // Unused upper data bits are held at 0, so XOR over the full byte is
    // the XOR over the configured data bits.
    function automatic logic parity_bit(input logic [7:0] data, input par_mode_e mode);
        return (mode == PAR_EVEN) ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO with show-ahead read and asynchronous active-low reset
// (contents included).
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   push_i       : write request
//   wdata_i      : write data
//   pop_i        : read request, ignored when empty
//   rdata_o      : head entry (valid while not empty)
//   empty_o      : FIFO empty
//   full_o       : FIFO full
//   overflow_o   : push rejected this cycle (full and no pop)
// Parameters: DATA_W, DEPTH (power of 2, >= 2), AW = log2(DEPTH).
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              pop_ok;
    logic              push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the slot, so push while full succeeds.
    assign pop_ok     = pop_i & ~empty_o;
    assign push_ok    = push_i & (~full_o | pop_ok);
    assign overflow_o = push_i & ~push_ok;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: 5..8 data bits, optional odd/even parity, 1 or 2 stop bits.
// One bit period = 2*(cfg_divisor+1) app_clk cycles; bits are sampled at
// mid-bit. Received bytes go into a show-ahead FIFO (uart_rx_fifo).
//
// Ports:
//   app_clk, reset_n       : clock, asynchronous active-low reset
//   cfg_rx_enable          : receiver enable (drop aborts the current frame)
//   cfg_data_bits          : data bits minus 5
//   cfg_stop_bits          : 0 = one stop bit, 1 = two stop bits
//   cfg_pen / cfg_epen     : parity enable / 1 = even, 0 = odd
//   cfg_divisor            : half bit period minus 1
//   rxd                    : asynchronous serial input, idles high
//   rx_fifo_rd             : pop request
//   rx_fifo_rdata          : FIFO head, unused upper bits 0
//   rx_fifo_empty/full     : FIFO flags
//   rx_busy                : frame in progress (FSM not idle)
//   rx_par_err             : one-cycle pulse, parity mismatch
//   rx_frm_err             : one-cycle pulse, stop bit sampled low
//   rx_overrun             : one-cycle pulse, byte dropped on full FIFO
//   rx_break               : (UART_RX_BREAK_DET_EN only) one-cycle pulse,
//                            all-zero frame including STOP1; nothing pushed
//
// Optional feature macro: UART_RX_BREAK_DET_EN
// Error/break pulses are registered and appear together with the FIFO
// going non-empty, one cycle after the final stop sample.
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        app_clk,
    input  logic        reset_n,
    input  logic        cfg_rx_enable,
    input  logic [1:0]  cfg_data_bits,
    input  logic        cfg_stop_bits,
    input  logic        cfg_pen,
    input  logic        cfg_epen,
    input  logic [15:0] cfg_divisor,
    input  logic        rxd,
    input  logic        rx_fifo_rd,
    output logic [7:0]  rx_fifo_rdata,
    output logic        rx_fifo_empty,
    output logic        rx_fifo_full,
    output logic        rx_busy,
    output logic        rx_par_err,
    output logic        rx_frm_err,
    output logic        rx_overrun
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic        rx_break
`endif
);

    localparam logic [2:0] LAST_BIT_OFS = 3'(DATA_BITS_OFFSET - 1);

    logic                   rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic                   rxd_fall;

    rx_state_e              state_q, state_d;
    logic [BIT_TIMER_W-1:0] cnt_q, cnt_d;
    logic [BIT_TIMER_W-1:0] full_period;
    logic                   tick;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   last_bit;
    logic [7:0]             data_q, data_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;

    logic                   latch_cfg;
    logic [1:0]             data_bits_q;
    logic                   stop_bits_q;
    par_mode_e              par_mode_q;
    logic [15:0]            div_q;

    logic                   push;
    logic                   fifo_overflow;
    logic                   par_pulse_q, par_pulse_d;
    logic                   frm_pulse_q, frm_pulse_d;
    logic                   ovr_pulse_q;

`ifdef UART_RX_BREAK_DET_EN
    logic                   seen_one_q, seen_one_d;
    logic                   brk_pulse_q, brk_pulse_d;
`endif

    // Two-flop synchroniser plus one history flop for edge detection.
    // Preset high so reset release never looks like a start edge.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign rxd_fall    = rxd_prev_q & ~rxd_s_q;
    // Down-counter reloads with N-1 so a sample fires every N cycles.
    assign full_period = {div_q, 1'b1};
    assign tick        = (cnt_q == '0);
    assign last_bit    = (bit_cnt_q == ({1'b0, data_bits_q} + LAST_BIT_OFS));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        latch_cfg   = 1'b0;
        push        = 1'b0;
        par_pulse_d = 1'b0;
        frm_pulse_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        seen_one_d  = seen_one_q;
        brk_pulse_d = 1'b0;
`endif

        if (state_q != RX_IDLE && state_q != RX_WAIT_IDLE && !tick) begin
            cnt_d = cnt_q - BIT_TIMER_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (cfg_rx_enable && rxd_fall) begin
                    state_d   = RX_START;
                    cnt_d     = {1'b0, cfg_divisor};
                    latch_cfg = 1'b1;
                    bit_cnt_d = '0;
                    data_d    = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    seen_one_d = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (tick) begin
                    cnt_d   = full_period;
                    state_d = rxd_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    cnt_d                = full_period;
                    data_d[bit_cnt_q]    = rxd_s_q;
`ifdef UART_RX_BREAK_DET_EN
                    seen_one_d           = seen_one_q | rxd_s_q;
`endif
                    if (last_bit) begin
                        state_d = (par_mode_q != PAR_NONE) ? RX_PARITY : RX_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    cnt_d     = full_period;
                    par_err_d = (rxd_s_q != parity_bit(data_q, par_mode_q));
`ifdef UART_RX_BREAK_DET_EN
                    seen_one_d = seen_one_q | rxd_s_q;
`endif
                    state_d   = RX_STOP1;
                end
            end
            RX_STOP1: begin
                if (tick) begin
                    cnt_d     = full_period;
                    frm_err_d = ~rxd_s_q;
`ifdef UART_RX_BREAK_DET_EN
                    if (!rxd_s_q && !seen_one_q) begin
                        brk_pulse_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end else
`endif
                    if (stop_bits_q) begin
                        state_d = RX_STOP2;
                    end else begin
                        push        = 1'b1;
                        par_pulse_d = par_err_q;
                        frm_pulse_d = ~rxd_s_q;
                        state_d     = rxd_s_q ? RX_IDLE : RX_WAIT_IDLE;
                    end
                end
            end
            RX_STOP2: begin
                if (tick) begin
                    cnt_d       = full_period;
                    push        = 1'b1;
                    par_pulse_d = par_err_q;
                    frm_pulse_d = frm_err_q | ~rxd_s_q;
                    state_d     = rxd_s_q ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Disable aborts the frame silently; anything decided this cycle is dropped.
        if (!cfg_rx_enable && state_q != RX_IDLE) begin
            state_d     = RX_IDLE;
            push        = 1'b0;
            par_pulse_d = 1'b0;
            frm_pulse_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_pulse_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            data_bits_q <= '0;
            stop_bits_q <= 1'b0;
            par_mode_q  <= PAR_NONE;
            div_q       <= '0;
            par_pulse_q <= 1'b0;
            frm_pulse_q <= 1'b0;
            ovr_pulse_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            seen_one_q  <= 1'b0;
            brk_pulse_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            par_pulse_q <= par_pulse_d;
            frm_pulse_q <= frm_pulse_d;
            ovr_pulse_q <= fifo_overflow;
`ifdef UART_RX_BREAK_DET_EN
            seen_one_q  <= seen_one_d;
            brk_pulse_q <= brk_pulse_d;
`endif
            if (latch_cfg) begin
                data_bits_q <= cfg_data_bits;
                stop_bits_q <= cfg_stop_bits;
                par_mode_q  <= !cfg_pen ? PAR_NONE : (cfg_epen ? PAR_EVEN : PAR_ODD);
                div_q       <= cfg_divisor;
            end
        end
    end

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk_i      (app_clk),
        .rst_ni     (reset_n),
        .push_i     (push),
        .wdata_i    (data_d),
        .pop_i      (rx_fifo_rd),
        .rdata_o    (rx_fifo_rdata),
        .empty_o    (rx_fifo_empty),
        .full_o     (rx_fifo_full),
        .overflow_o (fifo_overflow)
    );

    assign rx_busy    = (state_q != RX_IDLE);
    assign rx_par_err = par_pulse_q;
    assign rx_frm_err = frm_pulse_q;
    assign rx_overrun = ovr_pulse_q;
`ifdef UART_RX_BREAK_DET_EN
    assign rx_break   = brk_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core with cfg_divisor = 3 (8-cycle bit period).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic        app_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cfg_rx_enable;
    logic [1:0]  cfg_data_bits;
    logic        cfg_stop_bits;
    logic        cfg_pen;
    logic        cfg_epen;
    logic [15:0] cfg_divisor;
    logic        rxd = 1'b1;
    logic        rx_fifo_rd = 1'b0;
    logic [7:0]  rx_fifo_rdata;
    logic        rx_fifo_empty;
    logic        rx_fifo_full;
    logic        rx_busy;
    logic        rx_par_err;
    logic        rx_frm_err;
    logic        rx_overrun;
`ifdef UART_RX_BREAK_DET_EN
    logic        rx_break;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int par_cnt  = 0;
    int frm_cnt  = 0;
    int ovr_cnt  = 0;
    int brk_cnt  = 0;

    uart_rx_core #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2)
    ) dut (
        .app_clk       (app_clk),
        .reset_n       (reset_n),
        .cfg_rx_enable (cfg_rx_enable),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop_bits (cfg_stop_bits),
        .cfg_pen       (cfg_pen),
        .cfg_epen      (cfg_epen),
        .cfg_divisor   (cfg_divisor),
        .rxd           (rxd),
        .rx_fifo_rd    (rx_fifo_rd),
        .rx_fifo_rdata (rx_fifo_rdata),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_full  (rx_fifo_full),
        .rx_busy       (rx_busy),
        .rx_par_err    (rx_par_err),
        .rx_frm_err    (rx_frm_err),
        .rx_overrun    (rx_overrun)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .rx_break      (rx_break)
`endif
    );

    always #5 app_clk = ~app_clk;

    // Pulse counters
    always @(negedge app_clk) begin
        if (rx_par_err === 1'b1) par_cnt++;
        if (rx_frm_err === 1'b1) frm_cnt++;
        if (rx_overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_BREAK_DET_EN
        if (rx_break === 1'b1) brk_cnt++;
`endif
    end

    task automatic clear_counts();
        par_cnt = 0;
        frm_cnt = 0;
        ovr_cnt = 0;
        brk_cnt = 0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge app_clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (8) @(negedge app_clk);
    endtask

    // Serial frame as the agent sends it; line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit even, input bit bad_par,
                              input logic stop_lvl, input int nstop);
        logic p;
        p = even ? 1'b0 : 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(d[i]);
            p = p ^ d[i];
        end
        if (bad_par) p = ~p;
        if (pen) drive_bit(p);
        for (int i = 0; i < nstop; i++) drive_bit(stop_lvl);
    endtask

    task automatic pop_byte();
        rx_fifo_rd = 1'b1;
        @(negedge app_clk);
        rx_fifo_rd = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic sb, input logic pen, input logic ep);
        cfg_data_bits = db;
        cfg_stop_bits = sb;
        cfg_pen       = pen;
        cfg_epen      = ep;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge app_clk);
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b expected 1", rx_fifo_empty); end
        n_checks++; if (rx_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b expected 0", rx_fifo_full); end
        n_checks++; if (rx_fifo_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h expected 00", rx_fifo_rdata); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", rx_busy); end
        n_checks++; if ({rx_par_err, rx_frm_err, rx_overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b expected 000", {rx_par_err, rx_frm_err, rx_overrun}); end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_8n1();
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        clear_counts();
        send_frame(8'hA5, 8, 0, 0, 0, 1'b1, 1);
        idle(2);
        n_checks++; if (rx_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL 8n1_empty got %b expected 0", rx_fifo_empty); end
        n_checks++; if (rx_fifo_rdata !== 8'hA5) begin n_fail++; $display("FAIL 8n1_rdata got %h expected a5", rx_fifo_rdata); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy got %b expected 0", rx_busy); end
        n_checks++; if (par_cnt + frm_cnt + ovr_cnt !== 0) begin n_fail++; $display("FAIL 8n1_errs got %0d expected 0", par_cnt + frm_cnt + ovr_cnt); end
        pop_byte();
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL 8n1_pop_empty got %b expected 1", rx_fifo_empty); end
    endtask

    task automatic test_parity();
        set_cfg(2'd2, 1'b1, 1'b1, 1'b1);
        clear_counts();
        send_frame(8'h3C, 7, 1, 1, 0, 1'b1, 2);
        idle(2);
        n_checks++; if (rx_fifo_rdata !== 8'h3C) begin n_fail++; $display("FAIL 7e2_rdata got %h expected 3c", rx_fifo_rdata); end
        n_checks++; if (par_cnt + frm_cnt !== 0) begin n_fail++; $display("FAIL 7e2_errs got %0d expected 0", par_cnt + frm_cnt); end
        pop_byte();
        set_cfg(2'd1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h15, 6, 1, 0, 1, 1'b1, 1);
        idle(2);
        n_checks++; if (rx_fifo_rdata !== 8'h15) begin n_fail++; $display("FAIL 6o1_rdata got %h expected 15", rx_fifo_rdata); end
        n_checks++; if (par_cnt !== 1) begin n_fail++; $display("FAIL 6o1_par_err got %0d expected 1", par_cnt); end
        n_checks++; if (frm_cnt !== 0) begin n_fail++; $display("FAIL 6o1_frm_err got %0d expected 0", frm_cnt); end
        pop_byte();
    endtask

    task automatic test_frame_err();
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        clear_counts();
        send_frame(8'h5A, 8, 0, 0, 0, 1'b0, 1);
        n_checks++; if (rx_fifo_rdata !== 8'h5A) begin n_fail++; $display("FAIL ferr_rdata got %h expected 5a", rx_fifo_rdata); end
        n_checks++; if (frm_cnt !== 1) begin n_fail++; $display("FAIL ferr_frm_err got %0d expected 1", frm_cnt); end
        n_checks++; if (par_cnt !== 0) begin n_fail++; $display("FAIL ferr_par_err got %0d expected 0", par_cnt); end
        repeat (30) @(negedge app_clk);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_busy got %b expected 1", rx_busy); end
        pop_byte();
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_no_second_frame got empty=%b expected 1", rx_fifo_empty); end
        idle(6);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle_busy got %b expected 0", rx_busy); end
        send_frame(8'h33, 8, 0, 0, 0, 1'b1, 1);
        idle(2);
        n_checks++; if (rx_fifo_rdata !== 8'h33) begin n_fail++; $display("FAIL ferr_next_rdata got %h expected 33", rx_fifo_rdata); end
        n_checks++; if (frm_cnt !== 1) begin n_fail++; $display("FAIL ferr_next_frm got %0d expected 1", frm_cnt); end
        pop_byte();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        clear_counts();
        for (int i = 1; i <= 5; i++) begin
            exp = 8'(i);
            send_frame(exp, 8, 0, 0, 0, 1'b1, 1);
            idle(2);
        end
        n_checks++; if (rx_fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b expected 1", rx_fifo_full); end
        n_checks++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulses got %0d expected 1", ovr_cnt); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            n_checks++; if (rx_fifo_rdata !== exp) begin n_fail++; $display("FAIL ovr_pop%0d got %h expected %h", i, rx_fifo_rdata, exp); end
            pop_byte();
        end
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_empty got %b expected 1", rx_fifo_empty); end
        pop_byte();
        n_checks++; if (rx_fifo_empty !== 1'b1 || rx_fifo_full !== 1'b0) begin n_fail++; $display("FAIL ovr_pop_empty got empty=%b full=%b expected 1/0", rx_fifo_empty, rx_fifo_full); end
    endtask

    task automatic test_glitch();
        clear_counts();
        rxd = 1'b0;
        repeat (2) @(negedge app_clk);
        rxd = 1'b1;
        @(negedge app_clk);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start got busy=%b expected 1", rx_busy); end
        repeat (5) @(negedge app_clk);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b expected 0", rx_busy); end
        idle(20);
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_push got empty=%b expected 1", rx_fifo_empty); end
        n_checks++; if (par_cnt + frm_cnt + ovr_cnt !== 0) begin n_fail++; $display("FAIL glitch_flags got %0d expected 0", par_cnt + frm_cnt + ovr_cnt); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h77, 8, 0, 0, 0, 1'b1, 1);
        idle(2);
        rxd = 1'b0;
        repeat (20) @(negedge app_clk);
        n_checks++; if (rx_busy !== 1'b1 || rx_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL mid_pre got busy=%b empty=%b expected 1/0", rx_busy, rx_fifo_empty); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b expected 0", rx_busy); end
        n_checks++; if (rx_fifo_empty !== 1'b1 || rx_fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fifo got empty=%b full=%b expected 1/0", rx_fifo_empty, rx_fifo_full); end
        n_checks++; if (rx_fifo_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rdata got %h expected 00", rx_fifo_rdata); end
        rxd = 1'b1;
        @(negedge app_clk);
        reset_n = 1'b1;
        idle(10);
        n_checks++; if (rx_busy !== 1'b0 || rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_after got busy=%b empty=%b expected 0/1", rx_busy, rx_fifo_empty); end
    endtask

    task automatic test_break();
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        clear_counts();
        rxd = 1'b0;
        repeat (96) @(negedge app_clk);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL brk_wait_busy got %b expected 1", rx_busy); end
`ifdef UART_RX_BREAK_DET_EN
        n_checks++; if (brk_cnt !== 1) begin n_fail++; $display("FAIL brk_pulse got %0d expected 1", brk_cnt); end
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL brk_nopush got empty=%b expected 1", rx_fifo_empty); end
        n_checks++; if (frm_cnt + par_cnt !== 0) begin n_fail++; $display("FAIL brk_errs got %0d expected 0", frm_cnt + par_cnt); end
`else
        n_checks++; if (rx_fifo_empty !== 1'b0 || rx_fifo_rdata !== 8'h00) begin n_fail++; $display("FAIL brk_push got empty=%b rdata=%h expected 0/00", rx_fifo_empty, rx_fifo_rdata); end
        n_checks++; if (frm_cnt !== 1) begin n_fail++; $display("FAIL brk_frm_err got %0d expected 1", frm_cnt); end
        pop_byte();
`endif
        idle(6);
        n_checks++; if (rx_busy !== 1'b0 || rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL brk_after got busy=%b empty=%b expected 0/1", rx_busy, rx_fifo_empty); end
    endtask

    initial begin
        cfg_rx_enable = 1'b1;
        cfg_divisor   = 16'd3;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
